register_file: RTL and testbench
================================

Name: register_file

Overview:
- General-purpose register file for the MIPS datapath: 32 registers x 32 bits.
- Two independent combinational read ports and one clocked write port.
- Sits between instruction decode (register specifiers) and ALU/writeback.
- Register 0 is hard-wired to zero, per MIPS $zero convention.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of register specifiers; register count = 2**ADDR_WIDTH (32).

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset; clears all registers.
- ReadReg1  input  ADDR_WIDTH  register specifier for read port 1.
- ReadReg2  input  ADDR_WIDTH  register specifier for read port 2.
- WriteReg  input  ADDR_WIDTH  register specifier for the write port.
- WriteData  input  DATA_WIDTH  data to write.
- Reg_write_Control  input  1  write enable, active-high.
- ReadData1  output  DATA_WIDTH  contents of register ReadReg1.
- ReadData2  output  DATA_WIDTH  contents of register ReadReg2.

Behaviour:
- One clock domain (Clock). Reset is synchronous and active-high; the polarity and synchronicity are fixed.
- Storage: 32 registers of DATA_WIDTH bits, indexed 0..31. No X after reset.
- Reset: on a rising Clock edge with Reset=1, every register becomes 0. Reset has priority over any write in the same cycle.
  - Outputs therefore read 0 from the first edge after Reset is asserted.
  - Reset asserted mid-operation discards any pending write in that cycle.
- Write: on a rising Clock edge with Reset=0, Reg_write_Control=1 and WriteReg!=0, reg[WriteReg] <= WriteData. Latency is 1 edge.
- Writes are ignored when:
  - Reg_write_Control=0;
  - WriteReg=0 (register 0 stays 0 permanently).
- Read: purely combinational, zero cycle latency.
  - ReadData1 = reg[ReadReg1]; ReadData2 = reg[ReadReg2].
  - Register 0 always reads 0.
- Both read ports may address the same register; both return the same value.
- Read-during-write to the same address: read returns the old value until the rising edge, then the new value. There is no write-to-read bypass.
- No other state, handshake or error signalling.

Decomposition:
- Shared package (mips_pkg): DATA_WIDTH=32, ADDR_WIDTH=5, REG_COUNT=32, ZERO_REG=5'd0.
- No sub-module is needed; storage array, write logic and two read muxes live in one module. A read-port mux may be factored as a small function.

Test Plan:
- Reset: assert Reset=1 for one edge after writing r1=0xFFFFFFFF -> ReadData1 for r1 = 0x00000000; all 32 registers read 0.
- Zero register: write WriteReg=0, WriteData=0x12345678, enable=1 -> ReadReg1=0 gives 0x00000000.
- Basic write/read: write r1=0x9ABCDEF0, r2=0x00000002, r5=0x00000005 on successive edges -> ReadReg1=2, ReadReg2=5 give 0x00000002/0x00000005; ReadReg1=1 gives 0x9ABCDEF0.
- Write disabled: Reg_write_Control=0, WriteReg=5, WriteData=0xDEADBEEF, clock edge -> r5 still 0x00000005.
- Read-during-write: r3=0x11111111, then present WriteReg=3, WriteData=0x22222222, enable=1, ReadReg1=3 -> 0x11111111 before edge, 0x22222222 after.
- Reset vs write priority: Reset=1 and enable=1, WriteReg=7, WriteData=0xAAAAAAAA on same edge -> r7 reads 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared sizing constants for the MIPS datapath blocks.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file.sv
// MIPS general-purpose register file: two combinational read ports,
// one clocked write port, register 0 hard-wired to zero.
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Reg_write_Control,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  w_write_en;

    // Writes to $zero are dropped so entry 0 keeps its reset value forever.
    assign w_write_en = Reg_write_Control && (WriteReg != ZERO_ADDR);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_en) begin
            r_regs[WriteReg] <= WriteData;
        end
    end

    // No write-to-read bypass: a same-cycle write is visible only after the edge.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] entry
    );
        return (addr == ZERO_ADDR) ? '0 : entry;
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadReg1, r_regs[ReadReg1]);
        ReadData2 = read_port(ReadReg2, r_regs[ReadReg2]);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus corner-case sequences.
module tb_register_file;

    logic        Clock;
    logic        Reset;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        Reg_write_Control;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int n_tests = 0;
    int n_fail  = 0;

    register_file dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .ReadReg1          (ReadReg1),
        .ReadReg2          (ReadReg2),
        .WriteReg          (WriteReg),
        .WriteData         (WriteData),
        .Reg_write_Control (Reg_write_Control),
        .ReadData1         (ReadData1),
        .ReadData2         (ReadData2)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [11];

    // scoreboard check
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // drivers
    task automatic drive(input logic rst, input logic we, input logic [4:0] wreg,
                         input logic [31:0] wdata, input logic [4:0] rr1, input logic [4:0] rr2);
        Reset             = rst;
        Reg_write_Control = we;
        WriteReg          = wreg;
        WriteData         = wdata;
        ReadReg1          = rr1;
        ReadReg2          = rr2;
    endtask

    task automatic idle();
        Reset             = 1'b0;
        Reg_write_Control = 1'b0;
        WriteReg          = 5'd0;
        WriteData         = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] wreg, input logic [31:0] wdata);
        @(negedge Clock);
        drive(1'b0, 1'b1, wreg, wdata, ReadReg1, ReadReg2);
        @(posedge Clock);
        #1;
        idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd0,  5'd1,  32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 5'd1,  32'hFFFF_FFFF, 5'd1,  5'd0,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd1,  5'd1,  32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b1, 5'd1,  32'h9ABC_DEF0, 5'd1,  5'd2,  32'h9ABC_DEF0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 1'b1, 5'd2,  32'h0000_0002, 5'd2,  5'd1,  32'h0000_0002, 32'h9ABC_DEF0};
        vecs[6]  = '{1'b0, 1'b1, 5'd5,  32'h0000_0005, 5'd2,  5'd5,  32'h0000_0002, 32'h0000_0005};
        vecs[7]  = '{1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  32'h0000_0005, 32'h0000_0005};
        vecs[8]  = '{1'b0, 1'b1, 5'd31, 32'hA5A5_5A5A, 5'd31, 5'd30, 32'hA5A5_5A5A, 32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b1, 5'd7,  32'hAAAA_AAAA, 5'd7,  5'd1,  32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b0, 1'b0, 5'd7,  32'h5555_5555, 5'd31, 5'd5,  32'h0000_0000, 32'h0000_0000};

        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge Clock);
            drive(vecs[i].rst, vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].rr1, vecs[i].rr2);
            @(posedge Clock);
            #1;
            check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].exp2);
        end

        // Combinational reads: no clock edge between changing the address and sampling.
        @(negedge Clock);
        idle();
        write_reg(5'd1, 32'h9ABC_DEF0);
        write_reg(5'd2, 32'h0000_0002);
        @(negedge Clock);
        ReadReg1 = 5'd2;
        ReadReg2 = 5'd2;
        #1;
        check("same_reg_rd1", ReadData1, 32'h0000_0002);
        check("same_reg_rd2", ReadData2, 32'h0000_0002);
        ReadReg1 = 5'd1;
        #1;
        check("comb_read_r1", ReadData1, 32'h9ABC_DEF0);

        // Read-during-write: old value until the edge, new value after.
        write_reg(5'd3, 32'h1111_1111);
        @(negedge Clock);
        drive(1'b0, 1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd3);
        #1;
        check("rdw_before", ReadData1, 32'h1111_1111);
        @(posedge Clock);
        #1;
        check("rdw_after", ReadData1, 32'h2222_2222);
        idle();

        // Fill every register with a distinct value, then reset and scan all of them.
        for (int r = 1; r < 32; r++) begin
            write_reg(5'(r), 32'hC000_0000 | 32'(r));
        end
        @(negedge Clock);
        ReadReg1 = 5'd17;
        ReadReg2 = 5'd31;
        #1;
        check("fill_r17", ReadData1, 32'hC000_0011);
        check("fill_r31", ReadData2, 32'hC000_001F);
        @(negedge Clock);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge Clock);
        #1;
        idle();
        for (int r = 0; r < 32; r++) begin
            ReadReg1 = 5'(r);
            ReadReg2 = 5'(31 - r);
            #1;
            check($sformatf("post_rst_p1_r%0d", r), ReadData1, 32'h0);
            check($sformatf("post_rst_p2_r%0d", 31 - r), ReadData2, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
